// File: rtl/instruction_fetch_unit_if.sv
// Fetch/issue bus: ROM address/data, downstream control, and the issued instruction fields.
// valid/stall: an issued instruction is held stable while stall is high; stall never drops valid.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] address;
  logic [27:0]           instruction;
  logic                  stall;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  valid;
  logic [ADDR_WIDTH-1:0] pc;
  logic [3:0]            opcode;
  logic [7:0]            dest;
  logic [7:0]            src1;
  logic [7:0]            src0;
  logic [15:0]           immediate;
  logic                  hazard_stall;

  modport master (
    output address, valid, pc, opcode, dest, src1, src0, immediate, hazard_stall,
    input  instruction, stall, branch_taken, branch_target
  );

  modport slave (
    input  address, valid, pc, opcode, dest, src1, src0, immediate, hazard_stall,
    output instruction, stall, branch_taken, branch_target
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch/issue stage: owns the PC, latches ROM data into the issue register and
// inserts bubbles on read-after-write hazards against recently issued destinations.
module instruction_fetch_unit #(
  parameter int          ADDR_WIDTH   = 16,
  parameter int          HAZARD_DEPTH = 2,
  parameter logic [15:0] WRITE_MASK   = 16'h000E,
  parameter logic [15:0] READ_MASK    = 16'h000C
) (
  input  logic clk,
  input  logic rst,
  instruction_fetch_unit_if.master bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] issue_pc;
  logic [27:0]           ir;
  logic                  valid_q;

  logic                  sb_vld [HAZARD_DEPTH];
  logic [7:0]            sb_dst [HAZARD_DEPTH];

  logic [3:0]            in_op;
  logic                  raw;
  logic                  hazard;
  logic                  sb_shift;
  logic                  sb_in_vld;

  assign in_op = bus.instruction[27:24];

  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < HAZARD_DEPTH; i++) begin
      if (sb_vld[i] && (sb_dst[i] == bus.instruction[15:8] ||
                        sb_dst[i] == bus.instruction[7:0])) begin
        raw = 1'b1;
      end
    end
    raw = raw & READ_MASK[in_op];
  end

  // A hazard only matters when the instruction would otherwise issue this edge.
  assign hazard    = (state != START) && !bus.branch_taken && !bus.stall && raw;
  assign sb_shift  = (state != START) && (bus.branch_taken || !bus.stall);
  assign sb_in_vld = !bus.branch_taken && !hazard && WRITE_MASK[in_op];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= START;
      pc_q     <= '0;
      issue_pc <= '0;
      ir       <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        START: begin
          valid_q <= 1'b0;
          state   <= RUN;
        end
        default: begin
          if (bus.branch_taken) begin
            pc_q    <= bus.branch_target;
            valid_q <= 1'b0;
            state   <= FLUSH;
          end else if (!bus.stall) begin
            state <= RUN;
            if (hazard) begin
              valid_q <= 1'b0;
            end else begin
              ir       <= bus.instruction;
              issue_pc <= pc_q;
              valid_q  <= 1'b1;
              pc_q     <= pc_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Entry 0 is the most recent issue slot; bubbles and branches push invalid entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HAZARD_DEPTH; i++) begin
        sb_vld[i] <= 1'b0;
        sb_dst[i] <= '0;
      end
    end else if (sb_shift) begin
      sb_vld[0] <= sb_in_vld;
      sb_dst[0] <= bus.instruction[23:16];
      for (int i = 1; i < HAZARD_DEPTH; i++) begin
        sb_vld[i] <= sb_vld[i-1];
        sb_dst[i] <= sb_dst[i-1];
      end
    end
  end

  assign bus.address      = pc_q;
  assign bus.valid        = valid_q;
  assign bus.pc           = issue_pc;
  assign bus.opcode       = ir[27:24];
  assign bus.dest         = ir[23:16];
  assign bus.src1         = ir[15:8];
  assign bus.src0         = ir[7:0];
  assign bus.immediate    = ir[15:0];
  assign bus.hazard_stall = hazard;
  assign dbg_state        = state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed program plus randomized stall/branch/reset
// traffic, checked cycle by cycle against a behavioural model of the fetch stage.
module tb_instruction_fetch_unit;

  localparam int          AW    = 16;
  localparam int          DEPTH = 2;
  localparam logic [15:0] WMASK = 16'h000E;
  localparam logic [15:0] RMASK = 16'h000C;

  // clock/reset
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_fetch_unit #(
    .ADDR_WIDTH(AW), .HAZARD_DEPTH(DEPTH), .WRITE_MASK(WMASK), .READ_MASK(RMASK)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // ROM image, aliased on the low 8 address bits
  logic [27:0] rom [256];
  assign bus.instruction = rom[bus.address[7:0]];

  // counters
  int n_cmp = 0;
  int n_bad = 0;
  int n_hz  = 0;

  // reference model
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_ipc;
  logic [27:0]   m_instr;
  logic          m_valid;
  logic          m_first;
  int            sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [27:0] mk(input int op, input int d, input int s1, input int s0);
    logic [27:0] r;
    r = {op[3:0], d[7:0], s1[7:0], s0[7:0]};
    return r;
  endfunction

  task automatic model_reset();
    m_pc = '0; m_ipc = '0; m_instr = '0; m_valid = 1'b0; m_first = 1'b1;
    sb = {};
    for (int i = 0; i < DEPTH; i++) sb.push_back(-1);
  endtask

  task automatic sb_push(input int v);
    sb.push_front(v);
    void'(sb.pop_back());
  endtask

  // driver: one clock of stimulus, with combinational and registered checks
  task automatic step(input logic s, input logic b, input logic [AW-1:0] t);
    logic [27:0] ins;
    logic        hz;
    bus.stall = s; bus.branch_taken = b; bus.branch_target = t;
    #1;
    ins = rom[m_pc[7:0]];
    hz  = 1'b0;
    if (!m_first && !b && !s && RMASK[ins[27:24]]) begin
      foreach (sb[i]) begin
        if (sb[i] >= 0 && (sb[i] == int'(ins[15:8]) || sb[i] == int'(ins[7:0]))) hz = 1'b1;
      end
    end
    chk("address", bus.address, m_pc);
    chk("hazard_stall", bus.hazard_stall, hz);
    if (bus.hazard_stall) n_hz++;

    if (m_first) begin
      m_first = 1'b0; m_valid = 1'b0;
    end else if (b) begin
      m_pc = t; m_valid = 1'b0; sb_push(-1);
    end else if (!s) begin
      if (hz) begin
        m_valid = 1'b0; sb_push(-1);
      end else begin
        m_instr = ins; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 1'b1;
        sb_push(WMASK[ins[27:24]] ? int'(ins[23:16]) : -1);
      end
    end

    @(posedge clk);
    @(negedge clk);
    chk("valid", bus.valid, m_valid);
    chk("pc", bus.pc, m_ipc);
    chk("opcode", bus.opcode, m_instr[27:24]);
    chk("dest", bus.dest, m_instr[23:16]);
    chk("src1", bus.src1, m_instr[15:8]);
    chk("src0", bus.src0, m_instr[7:0]);
    chk("immediate", bus.immediate, m_instr[15:0]);
  endtask

  // asynchronous reset pulse landing mid-cycle
  task automatic pulse_reset();
    @(negedge clk);
    bus.stall = 1'b0; bus.branch_taken = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.valid, 1'b0);
    chk("async_rst_address", bus.address, '0);
    chk("async_rst_pc", bus.pc, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      rom[i] = mk($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    rom[0]     = mk(0, 0, 0, 0);   // NOP
    rom[1]     = mk(1, 1, 0, 2);   // STO R1,2
    rom[2]     = mk(1, 2, 0, 4);   // STO R2,4
    rom[3]     = mk(2, 0, 1, 2);   // ADD R0,R1,R2
    rom[4]     = mk(3, 4, 0, 6);   // SUB R4,R0,R6
    rom[8'h40] = mk(0, 0, 0, 0);
    rom[8'hFF] = mk(0, 0, 0, 0);

    rst = 1'b1;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
    #2;
    chk("rst_address", bus.address, '0);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_pc", bus.pc, '0);
    chk("rst_dest", bus.dest, '0);
    chk("rst_immediate", bus.immediate, '0);
    chk("rst_hazard", bus.hazard_stall, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // directed program: START, NOP, STO, STO, 2 bubbles, ADD, 2 bubbles, SUB
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, '0);
      if (k == 0) chk("start_valid", bus.valid, 1'b0);
      if (k == 6) begin
        chk("add_pc", bus.pc, 16'd3);
        chk("add_dest", bus.dest, 8'd0);
        chk("add_src1", bus.src1, 8'd1);
        chk("add_src0", bus.src0, 8'd2);
      end
    end
    chk("bubble_count", n_hz, 4);

    // external stall during straight-line code
    repeat (3) step(1'b1, 1'b0, '0);
    repeat (2) step(1'b0, 1'b0, '0);

    // branch overrides stall
    step(1'b1, 1'b1, 16'h0040);
    chk("br_valid", bus.valid, 1'b0);
    chk("br_address", bus.address, 16'h0040);
    step(1'b0, 1'b0, '0);
    chk("br_issue_pc", bus.pc, 16'h0040);
    chk("br_issue_valid", bus.valid, 1'b1);

    // PC wrap
    step(1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, '0);
    chk("wrap_pc", bus.pc, 16'hFFFF);
    chk("wrap_address", bus.address, 16'h0000);

    pulse_reset();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic          s;
      logic          b;
      logic [AW-1:0] t;
      if ($urandom_range(0, 299) == 0) pulse_reset();
      s = ($urandom_range(0, 99) < 15);
      b = ($urandom_range(0, 99) < 8);
      t = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFC + $urandom_range(0, 3))
                                      : AW'($urandom_range(0, 65535));
      step(s, b, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front-end fetch/issue stage for the lab processor.
- Owns the program counter and drives the address into the combinational instruction ROM. Latches the returned 28-bit instruction into an issue register and splits it into fields for the execute stage.
- Inserts bubbles on read-after-write register hazards via a small destination scoreboard, and handles taken branches and external stalls.

Parameters:
- ADDR_WIDTH, 16, program counter / ROM address width.
- HAZARD_DEPTH, 2, number of most recently issued instructions whose destination is checked (1..4).
- WRITE_MASK, 16'h000E, bit n set means opcode n writes register field [23:16].
- READ_MASK, 16'h000C, bit n set means opcode n reads register fields [15:8] and [7:0].

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- oAddress  out  ADDR_WIDTH  ROM address; equals PC register (combinational from PC).
- iInstruction  in  28  ROM data for oAddress, same cycle.
- iStall  in  1  freeze request from downstream.
- iBranchTaken  in  1  redirect request from execute.
- iBranchTarget  in  ADDR_WIDTH  redirect address.
- oValid  out  1  issue register holds a real instruction this cycle.
- oPC  out  ADDR_WIDTH  address of the issued instruction.
- oOpcode  out  4  bits [27:24].
- oDest  out  8  bits [23:16].
- oSrc1  out  8  bits [15:8].
- oSrc0  out  8  bits [7:0].
- oImmediate  out  16  bits [15:0].
- oHazardStall  out  1  high in any cycle where a bubble is inserted due to RAW.

Behaviour:
- Reset (async, any time, including mid-stall or mid-hazard):
  - PC=0; all field outputs=0; oPC=0; oValid=0; oHazardStall=0.
  - Scoreboard entries invalid; state=START.
- States: START, RUN, FLUSH.
  - START: one cycle after reset deassertion, oValid=0, PC held at 0, then RUN. Gives the ROM a settled address.
  - RUN: evaluated every edge, with priority branch > stall > hazard > issue.
  - FLUSH: one cycle after a taken branch; issue register invalid; instruction at the new PC is evaluated for hazard/issue exactly as in RUN; returns to RUN.
- Branch (iBranchTaken=1, any state except START):
  - PC <= iBranchTarget; oValid <= 0.
  - Scoreboard shifts in an invalid entry; state <= FLUSH.
  - Overrides iStall in the same cycle.
- Stall (iStall=1, no branch): PC, issue register, oValid, scoreboard and state all hold. oHazardStall=0.
- Hazard:
  - Condition: opcode of iInstruction has its READ_MASK bit set, and [15:8] or [7:0] equals the dest of any valid scoreboard entry.
  - Response: oValid <= 0; PC holds; scoreboard shifts in an invalid entry; oHazardStall=1 (combinational, same cycle as detection).
  - The hazard clears naturally after at most HAZARD_DEPTH bubbles.
- Issue (no branch/stall/hazard):
  - Issue register <= iInstruction; oPC <= PC; oValid <= 1; PC <= PC+1.
  - Scoreboard shifts in {valid = WRITE_MASK[opcode], dest = [23:16]}.
- Scoreboard: shift register of HAZARD_DEPTH entries; the oldest entry drops off each non-stalled cycle.
- PC arithmetic: unsigned, wraps 2^ADDR_WIDTH-1 -> 0 without any flag.
- Latency: ROM address to issued fields is 1 clock.
- Throughput: 1 instruction/cycle with no hazards.
- Outputs are registered except oAddress and oHazardStall.

Test Plan:
- Reset released with ROM {0:NOP, 1:STO R0,0, 2:STO R1,2} and no hazard opcodes -> START one cycle (oAddress=0, oValid=0), then oPC=0,1,2 on consecutive cycles with oValid=1; mid-run Reset pulse -> oValid=0, oAddress=0 asynchronously.
- STO R1,2 ; STO R2,4 ; ADD R0,R1,R2 (ADD reads R1, R2) -> ADD bubbles two cycles (oHazardStall=1 twice, PC held at 3), then issues with oPC=3, oDest=0, oSrc1=1, oSrc0=2.
- ADD R0,R1,R2 at 7 followed by SUB R4,R0,R6 at 8 -> SUB held two cycles, issued third cycle; HAZARD_DEPTH=1 build -> one bubble only.
- iStall high 3 cycles during straight-line code -> oPC, fields, oAddress frozen, oHazardStall=0; resumes at next address without skip or duplicate.
- iBranchTaken=1 with iBranchTarget=16'h0040 while iStall=1 -> next cycle oValid=0, oAddress=0x40; following cycle oPC=0x40, oValid=1.
- PC preloaded via branch to 16'hFFFF, issue -> oPC=FFFF, next oAddress=0000.
